fp_mul_arbiter: RTL and testbench

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter_if.sv | 29 ++
 rtl/fp_mul_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - request/response bus between requesters and the shared FP multiplier arbiter
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic                  resp_exception;
  logic                  resp_overflow;
  logic                  resp_underflow;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result,
           resp_exception, resp_overflow, resp_underflow
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result,
           resp_exception, resp_overflow, resp_underflow
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin arbiter sharing one single-precision multiplier (IDLE->ISSUE->RESP)
// Optional sticky per-requester flags: FP_MUL_ARB_STICKY_EN
module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  fp_mul_arbiter_if.slave        bus,
  output logic                   busy,
  input  logic [NUM_REQ-1:0]     sticky_clr,
  output logic [3*NUM_REQ-1:0]   sticky_flags
);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  state_t          state_q, state_d;
  logic [31:0]     op_a_q, op_b_q;
  logic [ID_W-1:0] op_id_q;
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] resp_id_q;
  logic [31:0]     resp_result_q;
  logic [2:0]      flags_q;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   cand;
  logic            accept;
  logic            resp_hs;

  logic [31:0]     mul_result;
  logic            mul_exc, mul_ovf, mul_unf;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    accept        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          bus.req_ready = NUM_REQ'(1) << grant_idx;
          accept        = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (bus.resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign resp_hs = (state_q == ST_RESP) && bus.resp_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_id_q       <= '0;
      last_q        <= ID_W'(NUM_REQ-1);
      resp_id_q     <= '0;
      resp_result_q <= '0;
      flags_q       <= '0;
    end else begin
      if (accept) begin
        op_a_q  <= bus.req_a[32*grant_idx +: 32];
        op_b_q  <= bus.req_b[32*grant_idx +: 32];
        op_id_q <= grant_idx;
        last_q  <= grant_idx;
      end
      if (state_q == ST_ISSUE) begin
        resp_result_q <= mul_result;
        flags_q       <= {mul_exc, mul_ovf, mul_unf};
        resp_id_q     <= op_id_q;
      end
    end
  end

  multiplication u_mul (
    .a_i        (op_a_q),
    .b_i        (op_b_q),
    .result_o   (mul_result),
    .exception_o(mul_exc),
    .overflow_o (mul_ovf),
    .underflow_o(mul_unf)
  );

  assign bus.resp_valid     = (state_q == ST_RESP);
  assign bus.resp_id        = resp_id_q;
  assign bus.resp_result    = resp_result_q;
  assign bus.resp_exception = flags_q[2];
  assign bus.resp_overflow  = flags_q[1];
  assign bus.resp_underflow = flags_q[0];
  assign busy               = (state_q != ST_IDLE);

`ifdef FP_MUL_ARB_STICKY_EN
  logic [3*NUM_REQ-1:0] sticky_q, sticky_d;

  // Clear is applied first so a same-cycle set still lands
  always_comb begin
    sticky_d = sticky_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sticky_clr[i]) sticky_d[3*i +: 3] = 3'b000;
      if (resp_hs && (resp_id_q == ID_W'(i))) sticky_d[3*i +: 3] = sticky_d[3*i +: 3] | flags_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic sticky_unused;
  assign sticky_unused = ^{sticky_clr, resp_hs};
  assign sticky_flags  = '0;
`endif
endmodule

// Combinational IEEE-754 single multiply: truncating, subnormals flushed to zero
module multiplication (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        exception_o,
  output logic        overflow_o,
  output logic        underflow_o
);
  logic        sign;
  logic [7:0]  ea, eb;
  logic [47:0] prod;
  logic        norm;
  logic [22:0] mant;
  logic [9:0]  exp_u;
  logic        prod_unused;

  assign sign        = a_i[31] ^ b_i[31];
  assign ea          = a_i[30:23];
  assign eb          = b_i[30:23];
  assign prod        = {1'b1, a_i[22:0]} * {1'b1, b_i[22:0]};
  assign norm        = prod[47];
  assign mant        = norm ? prod[46:24] : prod[45:23];
  assign exp_u       = {2'b00, ea} + {2'b00, eb} + {9'd0, norm} - 10'd127;
  assign prod_unused = ^prod[22:0];

  // exp_u is two's complement: bit 9 set means the biased exponent went negative
  always_comb begin
    result_o    = {sign, exp_u[7:0], mant};
    exception_o = 1'b0;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    if (ea == 8'hFF || eb == 8'hFF) begin
      exception_o = 1'b1;
      result_o    = {sign, 8'hFF, 23'd0};
    end else if (ea == 8'h00 || eb == 8'h00) begin
      result_o = {sign, 31'd0};
    end else if (exp_u[9] || exp_u == 10'd0) begin
      underflow_o = 1'b1;
      result_o    = {sign, 31'd0};
    end else if (exp_u >= 10'd255) begin
      overflow_o = 1'b1;
      result_o   = {sign, 8'hFF, 23'd0};
    end
  end
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - randomized self-checking bench for fp_mul_arbiter against a transaction-level model
module tb_fp_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 3;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic                 busy;
  logic [NUM_REQ-1:0]   sticky_clr;
  logic [3*NUM_REQ-1:0] sticky_flags;

  fp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (bus),
    .busy        (busy),
    .sticky_clr  (sticky_clr),
    .sticky_flags(sticky_flags)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one job in flight, response visible from the second cycle after accept
  bit              m_busy;
  int              m_age;
  int              m_last;
  logic [ID_W-1:0] m_id;
  logic [31:0]     m_res;
  logic [2:0]      m_flg;
  logic [2:0]      m_sticky [NUM_REQ];
  int              cyc = 0;
  int              gnt_id[$];
  int              gnt_cyc[$];

  function automatic void model_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [2:0] f);
    int   ea, eb, e;
    logic s;
    real  p;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    f  = 3'b000;
    if (ea == 255 || eb == 255) begin
      r = {s, 8'hFF, 23'd0};
      f = 3'b100;
    end else if (ea == 0 || eb == 0) begin
      r = {s, 31'd0};
    end else begin
      p = (1.0 + real'(a[22:0]) / 8388608.0) * (1.0 + real'(b[22:0]) / 8388608.0);
      e = ea + eb - 127;
      if (p >= 2.0) begin
        p = p / 2.0;
        e++;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = 3'b010;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 3'b001;
      end else begin
        r = {s, 8'(e), 23'(int'((p - 1.0) * 8388608.0))};
      end
    end
  endfunction

  function automatic logic [3*NUM_REQ-1:0] sticky_exp();
    logic [3*NUM_REQ-1:0] v;
    v = '0;
`ifdef FP_MUL_ARB_STICKY_EN
    for (int i = 0; i < NUM_REQ; i++) v[3*i +: 3] = m_sticky[i];
`endif
    return v;
  endfunction

  // Mantissas keep only 11 significant bits so the product is exact regardless of rounding
  function automatic logic [31:0] rand_fp();
    int          sel;
    logic [7:0]  e;
    logic [22:0] m;
    sel = $urandom_range(0, 15);
    m   = {11'($urandom), 12'd0};
    case (sel)
      0:       e = 8'hFF;
      1:       e = 8'h00;
      2, 3:    e = 8'($urandom_range(220, 254));
      4, 5:    e = 8'($urandom_range(1, 40));
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {1'($urandom), e, m};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_last = NUM_REQ - 1;
    m_id   = '0;
    m_res  = '0;
    m_flg  = '0;
    for (int i = 0; i < NUM_REQ; i++) m_sticky[i] = 3'b000;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[32*i +: 32] = rand_fp();
      bus.req_b[32*i +: 32] = rand_fp();
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns on the next falling edge
  task automatic step();
    logic [NUM_REQ-1:0] exp_rdy;
    int                 g;
    bit                 hs;
    #1;
    exp_rdy = '0;
    g       = -1;
    if (!m_busy) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_last + k) % NUM_REQ;
        if (g < 0 && bus.req_valid[c]) g = c;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("req_ready", bus.req_ready, exp_rdy);
    check("busy", busy, m_busy);
    check("resp_valid", bus.resp_valid, m_busy && m_age >= 1);
    if (m_busy && m_age >= 1) begin
      check("resp_id", bus.resp_id, m_id);
      check("resp_result", bus.resp_result, m_res);
      check("resp_flags", {bus.resp_exception, bus.resp_overflow, bus.resp_underflow}, m_flg);
    end
    check("sticky_flags", sticky_flags, sticky_exp());
    hs = m_busy && m_age >= 1 && bus.resp_ready;
    @(posedge CLK);
    if (RESET) begin
      model_reset();
    end else begin
`ifdef FP_MUL_ARB_STICKY_EN
      for (int i = 0; i < NUM_REQ; i++) if (sticky_clr[i]) m_sticky[i] = 3'b000;
      if (hs) m_sticky[m_id] = m_sticky[m_id] | m_flg;
`endif
      if (g >= 0) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_last = g;
        m_id   = ID_W'(g);
        model_mul(bus.req_a[32*g +: 32], bus.req_b[32*g +: 32], m_res, m_flg);
        gnt_id.push_back(g);
        gnt_cyc.push_back(cyc);
      end else if (hs) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_age++;
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 20) begin
      step();
      n++;
    end
    if (m_busy) check("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    RESET          = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    sticky_clr     = '0;
    @(posedge CLK);
    @(negedge CLK);
    model_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_id", bus.resp_id, 0);
    check("rst_resp_result", bus.resp_result, 0);
    check("rst_flags", {bus.resp_exception, bus.resp_overflow, bus.resp_underflow}, 0);
    check("rst_sticky", sticky_flags, 0);
    check("rst_req_ready", bus.req_ready, 0);
    @(negedge CLK);
    RESET = 1'b0;

    // Single request on requester 2: 5.0 * 5.0
    bus.req_valid         = 4'b0100;
    bus.req_a[64 +: 32]   = 32'h40A00000;
    bus.req_b[64 +: 32]   = 32'h40A00000;
    bus.resp_ready        = 1'b1;
    step();
    bus.req_valid = '0;
    step();
    #1;
    check("single_resp_valid", bus.resp_valid, 1);
    check("single_resp_id", bus.resp_id, 2);
    check("single_result", bus.resp_result, 32'h41C80000);
    check("single_flags", {bus.resp_exception, bus.resp_overflow, bus.resp_underflow}, 0);
    step();
    step();

    // Contention: all requesters valid straight after reset
    do_reset();
    gnt_id.delete();
    gnt_cyc.delete();
    bus.req_valid = '1;
    for (int n = 0; n < 15; n++) begin
      rand_ops();
      step();
    end
    check("contention_grants", gnt_id.size() >= 5, 1);
    if (gnt_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("contention_order", gnt_id[k], k % NUM_REQ);
      for (int k = 1; k < 5; k++) check("contention_spacing", gnt_cyc[k] - gnt_cyc[k-1], 3);
    end

    // Backpressure: hold resp_ready low in RESP
    bus.resp_ready = 1'b0;
    begin
      int n;
      n = 0;
      while (!(m_busy && m_age >= 1) && n < 10) begin
        step();
        n++;
      end
      check("bp_reach_resp", m_busy && m_age >= 1, 1);
    end
    for (int n = 0; n < 5; n++) begin
      rand_ops();
      step();
    end
    bus.resp_ready = 1'b1;
    step();
    #1;
    check("bp_idle_after_release", busy, 0);

    // Overflow on requester 1 and its sticky bit
    bus.req_valid = '0;
    wait_idle();
    bus.req_valid       = 4'b0010;
    bus.req_a[32 +: 32] = 32'h7F000000;
    bus.req_b[32 +: 32] = 32'h7F000000;
    step();
    bus.req_valid = '0;
    step();
    #1;
    check("ovf_flag", bus.resp_overflow, 1);
    check("ovf_resp_id", bus.resp_id, 1);
    step();
    step();
    step();
    #1;
`ifdef FP_MUL_ARB_STICKY_EN
    check("sticky_ovf_held", sticky_flags[5:3], 3'b010);
`else
    check("sticky_ovf_held", sticky_flags[5:3], 3'b000);
`endif
    sticky_clr = 4'b0010;
    step();
    sticky_clr = '0;
    step();
    #1;
    check("sticky_ovf_cleared", sticky_flags[5:3], 3'b000);

    // Reset while in ISSUE aborts the job
    bus.req_valid      = 4'b0001;
    bus.req_a[0 +: 32] = 32'h3F800000;
    bus.req_b[0 +: 32] = 32'h40000000;
    step();
    bus.req_valid = '0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_resp_valid", bus.resp_valid, 0);
    for (int n = 0; n < 4; n++) step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.req_valid  = NUM_REQ'($urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      sticky_clr     = ($urandom_range(0, 7) == 0) ? NUM_REQ'($urandom) : '0;
      RESET          = ($urandom_range(0, 99) == 0);
      rand_ops();
      step();
    end
    RESET = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
